// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared types and constants for the uart_tx arbiter
package uart_tx_arbiter_pkg;

   localparam int BYTE_W         = 8;
   localparam int DEF_TMO_CYCLES = 64;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } arb_state_t;

   // slot reached by stepping 'step' places past 'ptr' on a ring of 'n' requesters
   function automatic int rr_slot(input int ptr, input int step, input int n);
      return (ptr + step) % n;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin picker
module uart_tx_arbiter_rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int GNT_W = 2
) (
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ-1:0]  mask,
   input  logic [GNT_W-1:0] ptr,
   output logic             valid,
   output logic [GNT_W-1:0] idx
);

   logic [NREQ-1:0] w_elig;

   assign w_elig = req & mask;

   // scan ptr+1, ptr+2 .. ptr (wrapping); the first eligible requester wins
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!valid && w_elig[i] && (i == rr_slot(int'(ptr), k, NREQ))) begin
               valid = 1'b1;
               idx   = GNT_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame-locking arbiter in front of one uart_tx
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NREQ       = 4,
   parameter int GNT_W      = $clog2(NREQ),
   parameter int TMO_CYCLES = DEF_TMO_CYCLES
) (
   input  logic                     bitclk,
   input  logic                     reset_n,
   input  logic [NREQ-1:0]          req,
   input  logic [BYTE_W*NREQ-1:0]   req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          ack,
   output logic                     tx_start,
   output logic [BYTE_W-1:0]        tx_data,
   input  logic                     tx_bsy,
   output logic [GNT_W-1:0]         grant,
   output logic                     locked,
   output logic                     busy,
   output logic                     err
);

   // one shared watchdog: start timeout while in START, lock timeout while idle and locked
   localparam int              WD_W    = $clog2(TMO_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TMO_CYCLES);

   arb_state_t          r_state;
   arb_state_t          w_next_state;

   logic [GNT_W-1:0]    r_ptr;
   logic [GNT_W-1:0]    r_grant;
   logic [BYTE_W-1:0]   r_tx_data;
   logic                r_tx_start;
   logic [NREQ-1:0]     r_ack;
   logic                r_locked;
   logic                r_last;
   logic                r_err;
   logic [WD_W-1:0]     r_wdog;

   logic [NREQ-1:0]     w_onehot;
   logic [NREQ-1:0]     w_mask;
   logic                w_req_owner;
   logic                w_pick_valid;
   logic [GNT_W-1:0]    w_pick_idx;
   logic [BYTE_W-1:0]   w_pick_data;
   logic                w_pick_last;

   logic                w_do_pick;
   logic                w_accept;
   logic                w_start_tmo;
   logic                w_lock_cnt;
   logic                w_lock_tmo;
   logic                w_busy;

   // owner decode: while locked only the current owner may be picked
   always_comb begin
      w_onehot    = '0;
      w_req_owner = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_grant == GNT_W'(i)) begin
            w_onehot[i] = 1'b1;
            w_req_owner = req[i];
         end
      end
      w_mask = r_locked ? w_onehot : {NREQ{1'b1}};
   end

   uart_tx_arbiter_rr_pick #(
      .NREQ  (NREQ),
      .GNT_W (GNT_W)
   ) u_rr_pick (
      .req   (req),
      .mask  (w_mask),
      .ptr   (r_ptr),
      .valid (w_pick_valid),
      .idx   (w_pick_idx)
   );

   // byte and frame-end flag of the picked requester
   always_comb begin
      w_pick_data = '0;
      w_pick_last = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick_idx == GNT_W'(i)) begin
            w_pick_data = req_data[BYTE_W*i +: BYTE_W];
            w_pick_last = req_last[i];
         end
      end
   end

   // FSM state register
   always_ff @(posedge bitclk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next state: IDLE waits for a free transmitter, START waits for bsy, BUSY waits for bsy low
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!tx_bsy && w_pick_valid) begin
               w_next_state = ST_START;
            end
         end
         ST_START: begin
            if (tx_bsy) begin
               w_next_state = ST_BUSY;
            end else if (r_wdog == WD_LAST) begin
               w_next_state = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (!tx_bsy) begin
               w_next_state = ST_IDLE;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // FSM outputs: per-state strobes that steer the datapath and watchdog
   always_comb begin
      w_do_pick   = 1'b0;
      w_accept    = 1'b0;
      w_start_tmo = 1'b0;
      w_lock_cnt  = 1'b0;
      w_busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy     = 1'b0;
            w_do_pick  = !tx_bsy && w_pick_valid;
            w_lock_cnt = r_locked && !w_req_owner;
         end
         ST_START: begin
            w_accept    = tx_bsy;
            w_start_tmo = !tx_bsy && (r_wdog == WD_LAST);
         end
         default: ;
      endcase
   end

   assign w_lock_tmo = w_lock_cnt && (r_wdog == WD_LAST);

   // datapath: latch the picked byte, handshake with uart_tx, pulse ack/err for one cycle
   always_ff @(posedge bitclk or negedge reset_n) begin
      if (!reset_n) begin
         r_ptr      <= GNT_W'(NREQ - 1);
         r_grant    <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_ack      <= '0;
         r_locked   <= 1'b0;
         r_last     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ack <= '0;
         r_err <= 1'b0;
         if (w_do_pick) begin
            r_grant    <= w_pick_idx;
            r_ptr      <= w_pick_idx;
            r_tx_data  <= w_pick_data;
            r_last     <= w_pick_last;
            r_tx_start <= 1'b1;
         end
         if (w_accept) begin
            r_tx_start <= 1'b0;
            r_ack      <= w_onehot;
            r_locked   <= ~r_last;
         end
         if (w_start_tmo) begin
            r_tx_start <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b1;
         end
         if (w_lock_tmo) begin
            r_locked <= 1'b0;
            r_err    <= 1'b1;
         end
      end
   end

   // watchdog: counts START cycles or idle-locked cycles with the owner silent; saturates
   always_ff @(posedge bitclk or negedge reset_n) begin
      if (!reset_n) begin
         r_wdog <= '0;
      end else if (w_do_pick || w_accept || w_start_tmo || w_lock_tmo) begin
         r_wdog <= '0;
      end else if ((r_state == ST_START) || w_lock_cnt) begin
         if (r_wdog != WD_SAT) begin
            r_wdog <= r_wdog + 1'b1;
         end
      end else begin
         r_wdog <= '0;
      end
   end

   assign ack      = r_ack;
   assign tx_start = r_tx_start;
   assign tx_data  = r_tx_data;
   assign grant    = r_grant;
   assign locked   = r_locked;
   assign busy     = w_busy;
   assign err      = r_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed and randomized checks of uart_tx_arbiter against a queue model
module tb_uart_tx_arbiter;

   localparam int NREQ  = 4;
   localparam int GNT_W = 2;
   localparam int TMO   = 16;

   logic                bitclk   = 1'b0;
   logic                reset_n  = 1'b0;
   logic [NREQ-1:0]     req      = '0;
   logic [8*NREQ-1:0]   req_data = '0;
   logic [NREQ-1:0]     req_last = '0;
   logic                tx_bsy   = 1'b0;
   logic [NREQ-1:0]     ack;
   logic                tx_start;
   logic [7:0]          tx_data;
   logic [GNT_W-1:0]    grant;
   logic                locked;
   logic                busy;
   logic                err;

   uart_tx_arbiter #(
      .NREQ       (NREQ),
      .GNT_W      (GNT_W),
      .TMO_CYCLES (TMO)
   ) dut (
      .bitclk   (bitclk),
      .reset_n  (reset_n),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .ack      (ack),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_bsy   (tx_bsy),
      .grant    (grant),
      .locked   (locked),
      .busy     (busy),
      .err      (err)
   );

   always #5 bitclk = ~bitclk;

   int n_total = 0;
   int n_pass  = 0;

   // per-requester pending bytes, the model's arbitration view and the transmitted stream
   byte unsigned q_data [NREQ][$];
   bit           q_last [NREQ][$];
   byte unsigned sent[$];
   byte unsigned order_log[$];
   int           m_ptr    = NREQ - 1;
   bit           m_locked = 1'b0;
   int           m_owner  = 0;

   bit dead            = 1'b0;
   int bsy_cnt         = 0;
   int start_while_bsy = 0;

   byte unsigned exp2 [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
   byte unsigned exp3 [4] = '{8'h10, 8'h11, 8'h12, 8'h20};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   // uart_tx stand-in: takes start when idle, stays busy for a random number of cycles
   initial forever begin
      @(posedge bitclk);
      #2;
      if (!reset_n) begin
         tx_bsy  = 1'b0;
         bsy_cnt = 0;
      end else if (dead) begin
         tx_bsy = 1'b0;
      end else if (tx_bsy) begin
         if (tx_start) start_while_bsy++;
         bsy_cnt--;
         if (bsy_cnt <= 0) tx_bsy = 1'b0;
      end else if (tx_start) begin
         tx_bsy  = 1'b1;
         bsy_cnt = int'($urandom_range(1, 4));
         sent.push_back(tx_data);
      end
   end

   task automatic drive_reqs();
      for (int i = 0; i < NREQ; i++) begin
         if (q_data[i].size() > 0) begin
            req[i]               = 1'b1;
            req_data[8*i +: 8]   = q_data[i][0];
            req_last[i]          = q_last[i][0];
         end else begin
            req[i] = 1'b0;
         end
      end
   endtask

   task automatic push_byte(input int r, input byte unsigned d, input bit last);
      q_data[r].push_back(d);
      q_last[r].push_back(last);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      dead    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         q_data[i].delete();
         q_last[i].delete();
      end
      drive_reqs();
      req_data = '0;
      req_last = '0;
      m_ptr    = NREQ - 1;
      m_locked = 1'b0;
      m_owner  = 0;
      repeat (2) @(negedge bitclk);
      sent.delete();
      order_log.delete();
      reset_n = 1'b1;
   endtask

   // who should win next: the lock owner, else the first pending requester after the last winner
   function automatic int model_pick();
      if (m_locked) return m_owner;
      for (int k = 1; k <= NREQ; k++) begin
         if (q_data[(m_ptr + k) % NREQ].size() > 0) return (m_ptr + k) % NREQ;
      end
      return -1;
   endfunction

   function automatic int pending_bytes();
      int n = 0;
      for (int i = 0; i < NREQ; i++) n += q_data[i].size();
      return n;
   endfunction

   // serve all queued bytes, checking every accepted byte against the model
   task automatic run_traffic(input int budget, output int first_ack);
      int           cyc;
      int           idx;
      bit           done;
      byte unsigned b;
      first_ack = -1;
      cyc       = 0;
      done      = 1'b0;
      drive_reqs();
      while (!done) begin
         @(negedge bitclk);
         cyc++;
         check("ack_onehot", 32'($countones(ack) <= 1), 1);
         check("no_err", 32'(err), 0);
         if (ack != '0) begin
            if (first_ack < 0) first_ack = cyc;
            idx = 0;
            for (int i = NREQ - 1; i >= 0; i--) if (ack[i]) idx = i;
            check("ack_owner", idx, model_pick());
            check("grant", 32'(grant), idx);
            check("ack_pending", 32'(q_data[idx].size() > 0), 1);
            check("tx_frame_seen", 32'(sent.size() != 0), 1);
            if (q_data[idx].size() > 0) begin
               if (sent.size() != 0) begin
                  b = sent.pop_front();
                  check("tx_byte", 32'(b), 32'(q_data[idx][0]));
               end
               check("locked", 32'(locked), 32'(!q_last[idx][0]));
               m_ptr    = idx;
               m_owner  = idx;
               m_locked = !q_last[idx][0];
               order_log.push_back(q_data[idx][0]);
               void'(q_data[idx].pop_front());
               void'(q_last[idx].pop_front());
            end
            drive_reqs();
         end
         if (pending_bytes() == 0 && !busy && !tx_bsy) begin
            done = 1'b1;
         end else if (cyc >= budget) begin
            check("traffic_budget_left", pending_bytes(), 0);
            done = 1'b1;
         end
      end
   endtask

   initial begin
      int fa;
      int err_cyc;
      bit ack_seen;
      bit got;
      int total;

      // reset values
      @(negedge bitclk);
      check("rst_tx_start", 32'(tx_start), 0);
      check("rst_tx_data", 32'(tx_data), 0);
      check("rst_ack", 32'(ack), 0);
      check("rst_grant", 32'(grant), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_err", 32'(err), 0);

      // single byte from requester 0
      do_reset();
      push_byte(0, 8'h55, 1'b1);
      drive_reqs();
      @(negedge bitclk);
      check("t1_tx_start", 32'(tx_start), 1);
      check("t1_tx_data", 32'(tx_data), 32'h55);
      check("t1_busy", 32'(busy), 1);
      check("t1_ack_early", 32'(ack), 0);
      run_traffic(200, fa);
      check("t1_latency", fa, 1);
      check("t1_count", order_log.size(), 1);
      check("t1_byte", 32'(order_log.size() > 0 ? order_log[0] : 8'h00), 32'h55);

      // all requesters, single-byte frames: strict rotation
      do_reset();
      push_byte(0, 8'hA0, 1'b1);
      push_byte(0, 8'hA0, 1'b1);
      push_byte(1, 8'hA1, 1'b1);
      push_byte(2, 8'hA2, 1'b1);
      push_byte(3, 8'hA3, 1'b1);
      run_traffic(300, fa);
      check("t2_count", order_log.size(), 5);
      for (int i = 0; i < 5; i++)
         check("t2_order", 32'(order_log.size() > i ? order_log[i] : 8'h00), 32'(exp2[i]));

      // three-byte frame from requester 1 is not interleaved with requester 2
      do_reset();
      push_byte(1, 8'h10, 1'b0);
      push_byte(1, 8'h11, 1'b0);
      push_byte(1, 8'h12, 1'b1);
      push_byte(2, 8'h20, 1'b1);
      run_traffic(300, fa);
      check("t3_count", order_log.size(), 4);
      for (int i = 0; i < 4; i++)
         check("t3_order", 32'(order_log.size() > i ? order_log[i] : 8'h00), 32'(exp3[i]));

      // start watchdog: transmitter never answers
      do_reset();
      dead          = 1'b1;
      req           = 4'b0001;
      req_data[7:0] = 8'h77;
      req_last[0]   = 1'b1;
      err_cyc       = -1;
      ack_seen      = 1'b0;
      for (int c = 1; c <= TMO + 4 && err_cyc < 0; c++) begin
         @(negedge bitclk);
         if (c == 1) check("t4_start_high", 32'(tx_start), 1);
         if (ack != '0) ack_seen = 1'b1;
         if (err) begin
            err_cyc = c;
            req     = '0;
            check("t4_start_dropped", 32'(tx_start), 0);
            check("t4_idle", 32'(busy), 0);
         end
      end
      check("t4_err_seen", 32'(err_cyc >= 0), 1);
      check("t4_err_window", 32'(err_cyc >= TMO && err_cyc <= TMO + 2), 1);
      check("t4_no_ack", 32'(ack_seen), 0);
      @(negedge bitclk);
      check("t4_err_one_cycle", 32'(err), 0);
      dead = 1'b0;

      // lock watchdog: owner 3 stops mid-frame, requester 0 then served
      do_reset();
      push_byte(3, 8'h33, 1'b0);
      run_traffic(200, fa);
      check("t5_locked", 32'(locked), 1);
      check("t5_owner", 32'(grant), 3);
      push_byte(0, 8'h44, 1'b1);
      drive_reqs();
      err_cyc  = -1;
      ack_seen = 1'b0;
      for (int c = 1; c <= TMO + 4 && err_cyc < 0; c++) begin
         @(negedge bitclk);
         if (ack != '0) ack_seen = 1'b1;
         if (err) begin
            err_cyc = c;
            check("t5_unlocked", 32'(locked), 0);
         end
      end
      check("t5_err_seen", 32'(err_cyc >= 0), 1);
      check("t5_no_ack_while_locked", 32'(ack_seen), 0);
      m_locked = 1'b0;
      order_log.delete();
      run_traffic(200, fa);
      check("t5_served", 32'(order_log.size() > 0 ? order_log[0] : 8'h00), 32'h44);

      // reset while the transmitter is busy
      do_reset();
      push_byte(1, 8'h61, 1'b1);
      drive_reqs();
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
         @(negedge bitclk);
         if (ack != '0) got = 1'b1;
      end
      check("t6_ack_seen", 32'(got), 1);
      check("t6_busy_before", 32'(busy), 1);
      reset_n = 1'b0;
      #1;
      check("t6_tx_start", 32'(tx_start), 0);
      check("t6_tx_data", 32'(tx_data), 0);
      check("t6_ack", 32'(ack), 0);
      check("t6_grant", 32'(grant), 0);
      check("t6_locked", 32'(locked), 0);
      check("t6_busy", 32'(busy), 0);
      check("t6_err", 32'(err), 0);
      do_reset();
      push_byte(2, 8'h22, 1'b1);
      push_byte(3, 8'h33, 1'b1);
      run_traffic(200, fa);
      check("t6_first", 32'(order_log.size() > 0 ? order_log[0] : 8'h00), 32'h22);

      // randomized frames on a random subset of requesters
      for (int round = 0; round < 3; round++) begin
         do_reset();
         total = 0;
         for (int r = 0; r < NREQ; r++) begin
            if ($urandom_range(0, 3) != 0) begin
               int nf = int'($urandom_range(1, 3));
               for (int f = 0; f < nf; f++) begin
                  int len = int'($urandom_range(1, 3));
                  for (int k = 0; k < len; k++) begin
                     push_byte(r, byte'($urandom_range(0, 255)), k == len - 1);
                     total++;
                  end
               end
            end
         end
         run_traffic(3000, fa);
         check("rand_all_sent", order_log.size(), total);
      end

      check("start_while_bsy", start_while_bsy, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
